count_seq_checker: RTL and testbench

//  Downstream monitor for the 3-bit synchronous up-counter (bits q2..q0). Same clock domain.

---
 rtl/count_chk_pkg.sv | 26 ++
 rtl/count_seq_checker_sat_counter.sv | 43 ++++
 rtl/count_seq_checker.sv | 189 ++++++++++++++++++
 tb/tb_count_seq_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_chk_pkg.sv
// count_chk_pkg
//   Shared definitions for the counter sequence checker: checker state
//   encoding, the width of the monitored count and the modulo-8 successor
//   helper used for the match compare.
package count_chk_pkg;

  localparam int CNT_W = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACQ  = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_ACQ  = ACQ,
    ST_LOCK = LOCK,
    ST_ERR  = ERR
  } chk_state_e;

  // Successor of a 3-bit count; 7 rolls over to 0 through truncation.
  function automatic logic [CNT_W-1:0] nxt3(input logic [CNT_W-1:0] prev);
    return prev + 3'd1;
  endfunction

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
// Ports
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset, forces q to 0
//   clr    in  1  synchronous clear, has priority over inc
//   inc    in  1  count up by one unless already at the maximum
//   q      out W  current count
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != MAX_VAL)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Monitors the 3-bit up-counter that shares this clock. Every enabled
//   sample must equal the previous sample plus one (mod 8). After LOCK_CNT
//   consecutive good increments the checker locks; while locked it counts
//   wraps (7->0) and flags mismatches with a sticky error and a saturating
//   error count.
// Ports
//   clk         in  1        rising-edge clock, shared with the counter
//   clr         in  1        asynchronous active-low clear
//   en          in  1        sample strobe for q2..q0
//   q0,q1,q2    in  1 each   counter bits, LSB..MSB
//   resync      in  1        drop lock and return to acquisition
//   err_clr     in  1        clear sticky error, leave the error state
//   locked      out 1        high while locked
//   wrap_pulse  out 1        one-cycle pulse per wrap seen while locked
//   epoch_cnt   out EPOCH_W  wraps seen while locked, modulo 2^EPOCH_W
//   seq_err     out 1        sticky mismatch-while-locked flag
//   err_cnt     out ERRC_W   saturating mismatch-while-locked count
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | out of reset, waiting for the first sample
// ACQ   | acquiring: counting consecutive good increments
// LOCK  | locked: mismatches are errors, wraps advance the epoch
// ERR   | mismatch seen while locked; waits for err_clr or resync
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int EPOCH_W  = 8,
  parameter int ERRC_W   = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               q0,
  input  logic               q1,
  input  logic               q2,
  input  logic               resync,
  input  logic               err_clr,
  output logic               locked,
  output logic               wrap_pulse,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               seq_err,
  output logic [ERRC_W-1:0]  err_cnt
);

  // LOCK_CNT tops out at 15, so the run length never exceeds 14.
  localparam int GOOD_W = 4;
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

  chk_state_e         state_q, state_d;
  logic [CNT_W-1:0]   prev_q, prev_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               locked_q, locked_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               seq_err_q, seq_err_d;
  logic               err_inc;

  logic [CNT_W-1:0]   cur;
  logic               match;
  logic               wrap;

  assign cur   = {q2, q1, q0};
  assign match = (cur == nxt3(prev_q));
  assign wrap  = match && (prev_q == 3'd7);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    good_d       = good_q;
    seq_err_d    = seq_err_q;
    epoch_d      = epoch_q;
    wrap_pulse_d = 1'b0;
    err_inc      = 1'b0;

    // Any enabled sample outside IDLE tracks prev, whatever else happens.
    if ((state_q != ST_IDLE) && en) begin
      prev_d = cur;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_ACQ;
          prev_d  = cur;
          good_d  = '0;
        end
      end

      ST_ACQ: begin
        if (resync) begin
          good_d = '0;
        end else begin
          if (err_clr) begin
            seq_err_d = 1'b0;
          end
          if (en) begin
            if (!match) begin
              good_d = '0;
            end else if (good_q == GOOD_LAST) begin
              state_d = ST_LOCK;
              good_d  = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end
        end
      end

      ST_LOCK: begin
        if (resync) begin
          state_d = ST_ACQ;
          good_d  = '0;
        end else begin
          // Cleared first so that a mismatch on the same edge re-sets it.
          if (err_clr) begin
            seq_err_d = 1'b0;
          end
          if (en) begin
            if (!match) begin
              state_d   = ST_ERR;
              seq_err_d = 1'b1;
              err_inc   = 1'b1;
            end else if (wrap) begin
              wrap_pulse_d = 1'b1;
              epoch_d      = epoch_q + EPOCH_W'(1);
            end
          end
        end
      end

      ST_ERR: begin
        if (resync) begin
          state_d = ST_ACQ;
          good_d  = '0;
        end else if (err_clr) begin
          state_d   = ST_ACQ;
          good_d    = '0;
          seq_err_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    locked_d = (state_d == ST_LOCK);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      epoch_q      <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      wrap_pulse_q <= wrap_pulse_d;
      epoch_q      <= epoch_d;
      seq_err_q    <= seq_err_d;
    end
  end

  // err_cnt is only ever cleared by the async clear.
  sat_counter #(
    .W (ERRC_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (clr),
    .clr   (1'b0),
    .inc   (err_inc),
    .q     (err_cnt)
  );

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign epoch_cnt  = epoch_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker
//   Directed scenarios plus a randomized phase, all checked against a
//   behavioural model of the checker kept in plain integer arithmetic.
module tb_count_seq_checker;

  localparam int LOCK_CNT = 4;
  localparam int EPOCH_W  = 8;
  localparam int ERRC_W   = 4;
  localparam int EPOCH_MOD = 1 << EPOCH_W;
  localparam int ERRC_MAX  = (1 << ERRC_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;
  localparam int M_ERR  = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic en = 1'b0;
  logic q0 = 1'b0, q1 = 1'b0, q2 = 1'b0;
  logic resync = 1'b0;
  logic err_clr = 1'b0;
  logic locked, wrap_pulse, seq_err;
  logic [EPOCH_W-1:0] epoch_cnt;
  logic [ERRC_W-1:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_mode, m_prev, m_good, m_epoch, m_errc, m_seq, m_wp;

  count_seq_checker #(
    .LOCK_CNT (LOCK_CNT),
    .EPOCH_W  (EPOCH_W),
    .ERRC_W   (ERRC_W)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .resync     (resync),
    .err_clr    (err_clr),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .epoch_cnt  (epoch_cnt),
    .seq_err    (seq_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_prev  = 0;
    m_good  = 0;
    m_epoch = 0;
    m_errc  = 0;
    m_seq   = 0;
    m_wp    = 0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input bit e, input int c, input bit rs, input bit ec);
    bit good_inc;
    good_inc = e && (c == (m_prev + 1) % 8);
    m_wp = 0;
    if (m_mode == M_IDLE) begin
      if (e) begin
        m_mode = M_ACQ;
        m_good = 0;
      end
    end else if (rs) begin
      m_mode = M_ACQ;
      m_good = 0;
    end else if (m_mode == M_ACQ) begin
      if (ec) m_seq = 0;
      if (e) begin
        if (!good_inc) m_good = 0;
        else if (m_good + 1 == LOCK_CNT) begin
          m_mode = M_LOCK;
          m_good = 0;
        end else m_good++;
      end
    end else if (m_mode == M_LOCK) begin
      if (ec) m_seq = 0;
      if (e && !good_inc) begin
        m_mode = M_ERR;
        m_seq  = 1;
        if (m_errc < ERRC_MAX) m_errc++;
      end else if (good_inc && m_prev == 7) begin
        m_wp    = 1;
        m_epoch = (m_epoch + 1) % EPOCH_MOD;
      end
    end else begin
      if (ec) begin
        m_mode = M_ACQ;
        m_good = 0;
        m_seq  = 0;
      end
    end
    if (e) m_prev = c;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"},     locked,     (m_mode == M_LOCK) ? 1 : 0);
    check({tag, ".wrap_pulse"}, wrap_pulse, m_wp);
    check({tag, ".epoch_cnt"},  epoch_cnt,  m_epoch);
    check({tag, ".seq_err"},    seq_err,    m_seq);
    check({tag, ".err_cnt"},    err_cnt,    m_errc);
  endtask

  // Called at posedge+1; drives inputs, takes one edge, checks at posedge+1.
  task automatic step(input bit e, input int c, input bit rs, input bit ec, input string tag);
    logic [2:0] cv;
    cv = c[2:0];
    q0 = cv[0];
    q1 = cv[1];
    q2 = cv[2];
    en = e;
    resync = rs;
    err_clr = ec;
    @(posedge clk);
    model_edge(e, c, rs, ec);
    #1;
    check_all(tag);
  endtask

  task automatic feed(input int c, input string tag);
    step(1'b1, c, 1'b0, 1'b0, tag);
  endtask

  // Async clear applied between edges; outputs must drop without a clock.
  task automatic pulse_clear(input string tag);
    clr = 1'b0;
    #1;
    model_reset();
    check({tag, ".locked0"},  locked,     0);
    check({tag, ".wrap0"},    wrap_pulse, 0);
    check({tag, ".epoch0"},   epoch_cnt,  0);
    check({tag, ".seqerr0"},  seq_err,    0);
    check({tag, ".errcnt0"},  err_cnt,    0);
    clr = 1'b1;
  endtask

  initial begin
    int c;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    clr = 1'b1;

    // Lock and first wrap
    for (int i = 0; i <= 4; i++) feed(i, "lock");
    check("lock_after_4", locked, 1);
    for (int i = 5; i <= 7; i++) feed(i, "lock_run");
    feed(0, "wrap");
    check("wrap_pulse_hi", wrap_pulse, 1);
    check("epoch_one", epoch_cnt, 1);
    feed(1, "post_wrap");
    check("wrap_pulse_lo", wrap_pulse, 0);

    // Async clear mid-stream with count 5 on the bus
    for (int i = 2; i <= 5; i++) feed(i, "pre_clr");
    pulse_clear("mid_clr");
    feed(7, "after_clr");
    check("after_clr_unlocked", locked, 0);
    for (int i = 0; i <= 2; i++) feed(i, "reacq");
    check("reacq_not_yet", locked, 0);
    feed(3, "reacq_lock");
    check("reacq_locked", locked, 1);

    // Error while locked, then err_clr
    pulse_clear("rst_err");
    feed(7, "err_setup");
    for (int i = 0; i <= 3; i++) feed(i, "err_setup");
    check("locked_at_3", locked, 1);
    feed(5, "err_hit");
    check("err_seq_err", seq_err, 1);
    check("err_err_cnt", err_cnt, 1);
    check("err_unlocked", locked, 0);
    feed(6, "err_hold");
    feed(7, "err_hold");
    check("err_still_unlocked", locked, 0);
    check("err_still_sticky", seq_err, 1);
    step(1'b0, 7, 1'b0, 1'b1, "err_clr");
    check("err_clr_seq_err", seq_err, 0);
    check("err_clr_err_cnt", err_cnt, 1);

    // Error-count saturation
    pulse_clear("rst_sat");
    c = 0;
    feed(c, "sat");
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < LOCK_CNT; j++) begin
        c = (c + 1) % 8;
        feed(c, "sat_lock");
      end
      c = (c + 2) % 8;
      feed(c, "sat_err");
      step(1'b0, c, 1'b0, 1'b1, "sat_clr");
    end
    check("err_cnt_saturated", err_cnt, 15);

    // Epoch modulo wrap: 260 wraps while locked
    pulse_clear("rst_epoch");
    for (int i = 0; i <= 4; i++) feed(i, "ep_lock");
    c = 4;
    for (int k = 0; k < 260 * 8; k++) begin
      c = (c + 1) % 8;
      feed(c, "epoch");
    end
    check("epoch_260_mod", epoch_cnt, 4);
    check("epoch_still_locked", locked, 1);

    // err_clr together with a sample of 2 in ERR
    pulse_clear("rst_hz");
    for (int i = 0; i <= 4; i++) feed(i, "hz_lock");
    feed(6, "hz_err");
    step(1'b1, 2, 1'b0, 1'b1, "hz_errclr_sample");
    check("hz_errclr_seq_err", seq_err, 0);
    for (int i = 3; i <= 5; i++) feed(i, "hz_reacq");
    check("hz_reacq_not_yet", locked, 0);
    feed(6, "hz_reacq");
    check("hz_prev_was_2", locked, 1);

    // resync together with a mismatch in LOCK
    step(1'b1, 0, 1'b1, 1'b0, "hz_resync");
    check("hz_resync_unlocked", locked, 0);
    check("hz_resync_err_cnt", err_cnt, 1);
    check("hz_resync_seq_err", seq_err, 0);

    // en=0 gaps between 6 and 7
    for (int i = 1; i <= 6; i++) feed(i, "hz_gap_lock");
    step(1'b0, 3, 1'b0, 1'b0, "hz_gap");
    step(1'b0, 1, 1'b0, 1'b0, "hz_gap");
    feed(7, "hz_gap_7");
    check("hz_gap_locked", locked, 1);
    check("hz_gap_no_err", seq_err, 0);

    // Randomized phase
    for (int k = 0; k < 800; k++) begin
      bit e, rs, ec;
      int r;
      if ($urandom_range(0, 199) == 0) pulse_clear("rnd_clr");
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 85) c = (m_prev + 1) % 8;
      else c = $urandom_range(0, 7);
      r = $urandom_range(0, 99);
      rs = (r < 4);
      ec = (r >= 4 && r < 10);
      step(e, c, rs, ec, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
